// File: rtl/rr_prio_arbiter.sv
// 8-way arbiter: fixed-priority or round-robin, with a hold limit.
// All outputs registered; 1-cycle req-to-gnt latency, 1-cycle turnaround.
module rr_prio_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       mode,
  input  logic [0:7] req,
  output logic [0:7] gnt,
  output logic [0:2] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_e            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        id_q, id_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [0:7]        gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              to_q, to_d;
  logic [2:0]        base;
  logic [2:0]        win;
  logic [2:0]        nxt;

  // Scan downward so the first hit in search order is the last write.
  always_comb begin
    win  = '0;
    base = mode ? ptr_q : 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[base + 3'(i)]) begin
        win = base + 3'(i);
      end
    end
  end

  assign nxt = id_q + 3'd1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = GRANT;
          id_d        = win;
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (!req[id_q] || cnt_q == HOLD_MAX) begin
          state_d = IDLE;
          ptr_d   = nxt;
          id_d    = '0;
          gnt_d   = '0;
          busy_d  = 1'b0;
          to_d    = req[id_q];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign busy    = busy_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Bench for rr_prio_arbiter: vector table, corner sequences,
// then random traffic against an owner/ptr reference model.
module tb_rr_prio_arbiter;

  localparam int MH = 4;

  logic       clk;
  logic       rstn;
  logic       mode;
  logic [0:7] req;
  logic [0:7] gnt;
  logic [0:2] gnt_id;
  logic       busy;
  logic       timeout;

  int checks;
  int errors;

  rr_prio_arbiter #(
    .MAX_HOLD(MH),
    .HOLD_W  (5)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .mode   (mode),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       mode;
    logic [0:7] req;
    logic [0:7] gnt;
    int         id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic r, logic m, logic [0:7] rq,
                              logic [0:7] g, int id, logic b,
                              logic t);
    vec_t v;
    v.rstn = r;
    v.mode = m;
    v.req  = rq;
    v.gnt  = g;
    v.id   = id;
    v.busy = b;
    v.to   = t;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, logic [0:7] eg, int eid,
                     logic eb, logic et);
    logic [12:0] got;
    logic [12:0] exp;
    got = {gnt, gnt_id, busy, timeout};
    exp = {eg, 3'(eid), eb, et};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got gnt=%b id=%0d busy=%b to=%b exp gnt=%b id=%0d busy=%b to=%b",
               name, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
    end
  endtask

  // Reference model: who owns the resource, for how long, next start.
  int   m_owner;
  int   m_held;
  int   m_ptr;
  logic m_to;

  function automatic void model_step(logic r, logic m, logic [0:7] rq);
    if (!r) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int i = 0; i < 8; i++) begin
        int c;
        c = m ? (m_ptr + i) % 8 : i;
        if (rq[c] && m_owner < 0) begin
          m_owner = c;
          m_held  = 1;
        end
      end
    end else if (!rq[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_to    = 1'b0;
    end else if (m_held == MH) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_held++;
    end
  endfunction

  initial begin
    logic [0:7] g;
    logic [0:7] r;
    logic [0:7] eg;
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    mode   = 1'b0;
    req    = '0;

    add(0, 0, 8'hFF, 8'h00, 0, 0, 0);
    add(0, 0, 8'hFF, 8'h00, 0, 0, 0);
    add(1, 0, 8'hFF, 8'b10000000, 0, 1, 0);
    add(1, 0, 8'b00101000, 8'h00, 0, 0, 0);
    add(1, 0, 8'b00101000, 8'b00100000, 2, 1, 0);
    add(1, 0, 8'b00101000, 8'b00100000, 2, 1, 0);
    add(1, 0, 8'b00001000, 8'h00, 0, 0, 0);
    add(1, 0, 8'b00001000, 8'b00001000, 4, 1, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 8'h00, 8'h00, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      g    = '0;
      g[k] = 1'b1;
      r    = '1;
      r[k] = 1'b0;
      add(1, 1, 8'hFF, g, k, 1, 0);
      add(1, 1, 8'hFF, g, k, 1, 0);
      add(1, 1, r, 8'h00, 0, 0, 0);
    end
    add(1, 1, 8'hFF, 8'b10000000, 0, 1, 0);
    add(1, 1, 8'h00, 8'h00, 0, 0, 0);
    for (int k = 0; k < MH; k++)
      add(1, 1, 8'b00010100, 8'b00010000, 3, 1, 0);
    add(1, 1, 8'b00010100, 8'h00, 0, 0, 1);
    add(1, 1, 8'b00010100, 8'b00000100, 5, 1, 0);
    add(1, 1, 8'h00, 8'h00, 0, 0, 0);
    for (int k = 0; k < MH; k++)
      add(1, 1, 8'b00010000, 8'b00010000, 3, 1, 0);
    add(1, 1, 8'b00010000, 8'h00, 0, 0, 1);
    add(1, 1, 8'b00010000, 8'b00010000, 3, 1, 0);
    add(1, 1, 8'h00, 8'h00, 0, 0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      rstn = vq[i].rstn;
      mode = vq[i].mode;
      req  = vq[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), vq[i].gnt, vq[i].id,
          vq[i].busy, vq[i].to);
    end

    // Asynchronous reset in the middle of a grant.
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    mode = 1'b1;
    req  = 8'b00000010;
    @(posedge clk);
    #1;
    chk("grant6", 8'b00000010, 6, 1, 0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("async_rst", 8'h00, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    req  = 8'hFF;
    @(posedge clk);
    #1;
    chk("post_rst_ptr0", 8'b10000000, 0, 1, 0);
    @(negedge clk);
    req = 8'h00;
    @(posedge clk);

    // Mode switch while owning: owner kept, next arbitration fixed.
    @(negedge clk);
    req = 8'b00001000;
    @(posedge clk);
    #1;
    chk("grant4", 8'b00001000, 4, 1, 0);
    @(negedge clk);
    req = 8'h00;
    @(posedge clk);
    @(negedge clk);
    req = 8'b10000101;
    @(posedge clk);
    #1;
    chk("rr_ptr5", 8'b00000100, 5, 1, 0);
    @(negedge clk);
    mode = 1'b0;
    @(posedge clk);
    #1;
    chk("mode_sw_hold1", 8'b00000100, 5, 1, 0);
    @(posedge clk);
    #1;
    chk("mode_sw_hold2", 8'b00000100, 5, 1, 0);
    @(negedge clk);
    req = 8'b10000001;
    @(posedge clk);
    #1;
    chk("release5", 8'h00, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("fixed_after", 8'b10000000, 0, 1, 0);

    // Random traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      rstn = (k == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      mode = 1'($urandom_range(0, 1));
      r    = 8'($urandom) & 8'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 3) != 0)
        r[m_owner] = 1'b1;
      req = r;
      @(posedge clk);
      model_step(rstn, mode, req);
      #1;
      eg = '0;
      if (m_owner >= 0)
        eg[m_owner] = 1'b1;
      chk($sformatf("rand%0d", k), eg,
          (m_owner >= 0) ? m_owner : 0, m_owner >= 0, m_to);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
